// File: rtl/blake3_round_iter.sv
// blake3_round_iter: iterative BLAKE3 compression core. One column/diagonal
// half-round datapath (four parallel G functions) is reused for ROUNDS full
// rounds. The message block is permuted after every diagonal half-round.
//
// Ports:
//   Clk          in   rising-edge clock
//   Rst_n        in   synchronous reset, active low
//   In_Valid_I   in   input block valid
//   In_Ready_O   out  core can accept a block (registered)
//   V_I          in   state words v0..v15, word i at [32i+31:32i]
//   M_I          in   message words m0..m15, same packing
//   Out_Valid_O  out  result valid (registered)
//   Out_Ready_I  in   downstream accepts the result
//   V_O          out  result words, same packing (registered)
//   Busy_O       out  high while rounds are being computed (registered)
module blake3_round_iter #(
   parameter int unsigned ROUNDS  = 7,
   parameter int unsigned OUT_XOR = 0
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         In_Valid_I,
   output logic         In_Ready_O,
   input  logic [511:0] V_I,
   input  logic [511:0] M_I,
   output logic         Out_Valid_O,
   input  logic         Out_Ready_I,
   output logic [511:0] V_O,
   output logic         Busy_O
);

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned N_WORDS = 16;
   localparam int unsigned BLK_W   = WORD_W * N_WORDS;
   localparam int unsigned H_W     = WORD_W * 8;
   localparam int unsigned RND_W   = 4;

   localparam logic PH_COL  = 1'b0;
   localparam logic PH_DIAG = 1'b1;

   // Parameter legality is checked at elaboration.
   if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
      $error("blake3_round_iter: ROUNDS must be in 1..15");
   end
   if (OUT_XOR > 1) begin : g_bad_out_xor
      $error("blake3_round_iter: OUT_XOR must be 0 or 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] a;
      logic [WORD_W-1:0] b;
      logic [WORD_W-1:0] c;
      logic [WORD_W-1:0] d;
   } quad_t;

   // BLAKE3 G mixing function; right rotations written as bit reorders.
   function automatic quad_t g_mix(input logic [WORD_W-1:0] a_i,
                                   input logic [WORD_W-1:0] b_i,
                                   input logic [WORD_W-1:0] c_i,
                                   input logic [WORD_W-1:0] d_i,
                                   input logic [WORD_W-1:0] x_i,
                                   input logic [WORD_W-1:0] y_i);
      logic [WORD_W-1:0] a, b, c, d, t;
      quad_t q;
      a = a_i + b_i + x_i;
      t = d_i ^ a;
      d = {t[15:0], t[31:16]};
      c = c_i + d;
      t = b_i ^ c;
      b = {t[11:0], t[31:12]};
      a = a + b + y_i;
      t = d ^ a;
      d = {t[7:0], t[31:8]};
      c = c + d;
      t = b ^ c;
      b = {t[6:0], t[31:7]};
      q.a = a;
      q.b = b;
      q.c = c;
      q.d = d;
      return q;
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_phase;
   logic [RND_W-1:0]   r_rnd;
   logic [BLK_W-1:0]   r_v;
   logic [BLK_W-1:0]   r_m;
   logic [H_W-1:0]     r_h;
   logic [BLK_W-1:0]   r_vo;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;
   logic               w_in_ready_nxt;
   logic               w_out_valid_nxt;
   logic               w_busy_nxt;
   logic               w_accept;
   logic               w_last;
   logic [WORD_W-1:0]  w_vw [N_WORDS];
   logic [WORD_W-1:0]  w_mw [N_WORDS];
   quad_t              w_g  [4];
   logic [BLK_W-1:0]   w_v_nxt;
   logic [BLK_W-1:0]   w_m_perm;
   logic [BLK_W-1:0]   w_fin;

   // Ready is gated so the cycle right after reset cannot accept a block.
   assign w_accept = (r_state == S_IDLE) && r_in_ready && In_Valid_I;
   assign w_last   = (r_phase == PH_DIAG) && (r_rnd == RND_W'(ROUNDS - 1));

   // Word views of the working state and message.
   always_comb begin : p_unpack
      for (int unsigned i = 0; i < N_WORDS; i++) begin
         w_vw[i] = r_v[WORD_W*i +: WORD_W];
         w_mw[i] = r_m[WORD_W*i +: WORD_W];
      end
   end

   // Operand routing for the four parallel G instances.
   always_comb begin : p_g_select
      if (r_phase == PH_COL) begin
         w_g[0] = g_mix(w_vw[0], w_vw[4], w_vw[8],  w_vw[12], w_mw[0],  w_mw[1]);
         w_g[1] = g_mix(w_vw[1], w_vw[5], w_vw[9],  w_vw[13], w_mw[2],  w_mw[3]);
         w_g[2] = g_mix(w_vw[2], w_vw[6], w_vw[10], w_vw[14], w_mw[4],  w_mw[5]);
         w_g[3] = g_mix(w_vw[3], w_vw[7], w_vw[11], w_vw[15], w_mw[6],  w_mw[7]);
      end else begin
         w_g[0] = g_mix(w_vw[0], w_vw[5], w_vw[10], w_vw[15], w_mw[8],  w_mw[9]);
         w_g[1] = g_mix(w_vw[1], w_vw[6], w_vw[11], w_vw[12], w_mw[10], w_mw[11]);
         w_g[2] = g_mix(w_vw[2], w_vw[7], w_vw[8],  w_vw[13], w_mw[12], w_mw[13]);
         w_g[3] = g_mix(w_vw[3], w_vw[4], w_vw[9],  w_vw[14], w_mw[14], w_mw[15]);
      end
   end

   // Scatter G results back to their state word positions (word 15 first).
   always_comb begin : p_v_next
      if (r_phase == PH_COL) begin
         w_v_nxt = {w_g[3].d, w_g[2].d, w_g[1].d, w_g[0].d,
                    w_g[3].c, w_g[2].c, w_g[1].c, w_g[0].c,
                    w_g[3].b, w_g[2].b, w_g[1].b, w_g[0].b,
                    w_g[3].a, w_g[2].a, w_g[1].a, w_g[0].a};
      end else begin
         w_v_nxt = {w_g[0].d, w_g[3].d, w_g[2].d, w_g[1].d,
                    w_g[1].c, w_g[0].c, w_g[3].c, w_g[2].c,
                    w_g[2].b, w_g[1].b, w_g[0].b, w_g[3].b,
                    w_g[3].a, w_g[2].a, w_g[1].a, w_g[0].a};
      end
   end

   // Message permutation: new m[i] = old m[P[i]], P = 2,6,3,10,7,0,4,13,1,11,12,5,9,14,15,8.
   assign w_m_perm = {w_mw[8],  w_mw[15], w_mw[14], w_mw[9],
                      w_mw[5],  w_mw[12], w_mw[11], w_mw[1],
                      w_mw[13], w_mw[4],  w_mw[0],  w_mw[7],
                      w_mw[10], w_mw[3],  w_mw[6],  w_mw[2]};

   // Optional feed-forward finalisation against the input chaining value.
   always_comb begin : p_finalise
      w_fin = w_v_nxt;
      if (OUT_XOR != 0) begin
         for (int unsigned i = 0; i < 8; i++) begin
            w_fin[WORD_W*i +: WORD_W] = w_v_nxt[WORD_W*i +: WORD_W]
                                      ^ w_v_nxt[WORD_W*(i+8) +: WORD_W];
            w_fin[WORD_W*(i+8) +: WORD_W] = w_v_nxt[WORD_W*(i+8) +: WORD_W]
                                          ^ r_h[WORD_W*i +: WORD_W];
         end
      end
   end

   // State register.
   always_ff @(posedge Clk) begin : p_state_reg
      if (!Rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin : p_next_state
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)    w_state_nxt = S_RUN;
         S_RUN:   if (w_last)      w_state_nxt = S_DONE;
         S_DONE:  if (Out_Ready_I) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the flags are registered.
   always_comb begin : p_out_decode
      w_in_ready_nxt  = 1'b0;
      w_out_valid_nxt = 1'b0;
      w_busy_nxt      = 1'b0;
      case (w_state_nxt)
         S_IDLE:  w_in_ready_nxt  = 1'b1;
         S_RUN:   w_busy_nxt      = 1'b1;
         S_DONE:  w_out_valid_nxt = 1'b1;
         default: ;
      endcase
   end

   // Handshake/status output registers.
   always_ff @(posedge Clk) begin : p_out_regs
      if (!Rst_n) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   // Working state, message, chaining value, round tracking and result.
   always_ff @(posedge Clk) begin : p_datapath
      if (!Rst_n) begin
         r_v     <= '0;
         r_m     <= '0;
         r_h     <= '0;
         r_vo    <= '0;
         r_rnd   <= '0;
         r_phase <= PH_COL;
      end else if (w_accept) begin
         r_v     <= V_I;
         r_m     <= M_I;
         r_h     <= V_I[H_W-1:0];
         r_rnd   <= '0;
         r_phase <= PH_COL;
      end else if (r_state == S_RUN) begin
         r_v <= w_v_nxt;
         if (r_phase == PH_DIAG) begin
            r_m     <= w_m_perm;
            r_rnd   <= r_rnd + RND_W'(1);
            r_phase <= PH_COL;
            if (w_last) begin
               r_vo <= w_fin;
            end
         end else begin
            r_phase <= PH_DIAG;
         end
      end
   end

   assign In_Ready_O  = r_in_ready;
   assign Out_Valid_O = r_out_valid;
   assign Busy_O      = r_busy;
   assign V_O         = r_vo;

endmodule

// File: tb/tb_blake3_round_iter.sv
// tb_blake3_round_iter: three cores (R7 finalised, R7 raw, R1 raw) checked every
// cycle against a transaction-level BLAKE3 model, plus directed latency,
// backpressure, back-to-back and mid-run reset scenarios and known-answer
// checks on the empty-input hash.
module tb_blake3_round_iter;

   localparam int ROUNDS_OF [3] = '{7, 7, 1};
   localparam int XOR_OF    [3] = '{1, 0, 0};
   localparam int GA   [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
   localparam int GB   [8]  = '{4, 5, 6, 7, 5, 6, 7, 4};
   localparam int GC   [8]  = '{8, 9, 10, 11, 10, 11, 8, 9};
   localparam int GD   [8]  = '{12, 13, 14, 15, 15, 12, 13, 14};
   localparam int PERM [16] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};

   localparam logic [511:0] EV = {32'h0000000B, 32'h0, 32'h0, 32'h0,
                                  32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667,
                                  32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                  32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
   localparam logic [255:0] HASH = {32'h62321FE4, 32'hCA939ACC, 32'hB712C1AD, 32'hC925CB9B,
                                    32'h49C9DC36, 32'hEA4D40A0, 32'hA6A1F9F5, 32'hB94913AF};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         a_vin, a_ordy, b_vin, b_ordy;
   logic [511:0] a_v, a_m, b_v, b_m;
   logic         o_rdy [3];
   logic         o_val [3];
   logic         o_busy[3];
   logic [511:0] o_vo  [3];

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   blake3_round_iter #(.ROUNDS(7), .OUT_XOR(1)) u_x7 (
      .Clk(clk), .Rst_n(rst_n), .In_Valid_I(a_vin), .In_Ready_O(o_rdy[0]),
      .V_I(a_v), .M_I(a_m), .Out_Valid_O(o_val[0]), .Out_Ready_I(a_ordy),
      .V_O(o_vo[0]), .Busy_O(o_busy[0]));

   blake3_round_iter #(.ROUNDS(7), .OUT_XOR(0)) u_r7 (
      .Clk(clk), .Rst_n(rst_n), .In_Valid_I(a_vin), .In_Ready_O(o_rdy[1]),
      .V_I(a_v), .M_I(a_m), .Out_Valid_O(o_val[1]), .Out_Ready_I(a_ordy),
      .V_O(o_vo[1]), .Busy_O(o_busy[1]));

   blake3_round_iter #(.ROUNDS(1), .OUT_XOR(0)) u_r1 (
      .Clk(clk), .Rst_n(rst_n), .In_Valid_I(b_vin), .In_Ready_O(o_rdy[2]),
      .V_I(b_v), .M_I(b_m), .Out_Valid_O(o_val[2]), .Out_Ready_I(b_ordy),
      .V_O(o_vo[2]), .Busy_O(o_busy[2]));

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference compression: straight-line BLAKE3 rounds on word arrays.
   function automatic logic [511:0] model_raw(input logic [511:0] vin,
                                              input logic [511:0] min,
                                              input int rounds);
      logic [31:0] v [16];
      logic [31:0] m [16];
      logic [31:0] mp[16];
      logic [511:0] r;
      for (int i = 0; i < 16; i++) begin
         v[i] = vin[32*i +: 32];
         m[i] = min[32*i +: 32];
      end
      for (int rd = 0; rd < rounds; rd++) begin
         for (int g = 0; g < 8; g++) begin
            v[GA[g]] = v[GA[g]] + v[GB[g]] + m[2*g];
            v[GD[g]] = rotr(v[GD[g]] ^ v[GA[g]], 16);
            v[GC[g]] = v[GC[g]] + v[GD[g]];
            v[GB[g]] = rotr(v[GB[g]] ^ v[GC[g]], 12);
            v[GA[g]] = v[GA[g]] + v[GB[g]] + m[2*g+1];
            v[GD[g]] = rotr(v[GD[g]] ^ v[GA[g]], 8);
            v[GC[g]] = v[GC[g]] + v[GD[g]];
            v[GB[g]] = rotr(v[GB[g]] ^ v[GC[g]], 7);
         end
         for (int i = 0; i < 16; i++) mp[i] = m[PERM[i]];
         m = mp;
      end
      for (int i = 0; i < 16; i++) r[32*i +: 32] = v[i];
      return r;
   endfunction

   function automatic logic [511:0] fold(input logic [511:0] raw, input logic [511:0] vin);
      logic [511:0] r;
      for (int i = 0; i < 8; i++) begin
         r[32*i +: 32]     = raw[32*i +: 32] ^ raw[32*(i+8) +: 32];
         r[32*(i+8) +: 32] = raw[32*(i+8) +: 32] ^ vin[32*i +: 32];
      end
      return r;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(input string name, input int d, input logic [511:0] got,
                        input logic [511:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s dut%0d got=%0h exp=%0h", name, d, got, exp);
   endtask

   // Transaction-level expectation per core: idle / counting down / holding.
   bit           e_rdy [3];
   bit           e_val [3];
   bit           e_busy[3];
   logic [511:0] e_vo  [3];
   logic [511:0] e_pend[3];
   int           e_left[3];
   logic         m_vin, m_ordy;
   logic [511:0] m_vi, m_mi;

   always @(posedge clk) begin : model
      for (int d = 0; d < 3; d++) begin
         m_vin  = (d < 2) ? a_vin  : b_vin;
         m_ordy = (d < 2) ? a_ordy : b_ordy;
         m_vi   = (d < 2) ? a_v    : b_v;
         m_mi   = (d < 2) ? a_m    : b_m;
         if (!rst_n) begin
            e_rdy[d] = 1'b0; e_val[d] = 1'b0; e_busy[d] = 1'b0;
            e_vo[d] = '0; e_left[d] = 0;
         end else if (e_val[d]) begin
            if (m_ordy) begin
               e_val[d] = 1'b0;
               e_rdy[d] = 1'b1;
            end
         end else if (e_busy[d]) begin
            e_left[d]--;
            if (e_left[d] == 0) begin
               e_busy[d] = 1'b0;
               e_val[d]  = 1'b1;
               e_vo[d]   = e_pend[d];
            end
         end else if (m_vin && e_rdy[d]) begin
            e_pend[d] = model_raw(m_vi, m_mi, ROUNDS_OF[d]);
            if (XOR_OF[d] != 0) e_pend[d] = fold(e_pend[d], m_vi);
            e_left[d] = 2 * ROUNDS_OF[d];
            e_busy[d] = 1'b1;
            e_rdy[d]  = 1'b0;
         end else begin
            e_rdy[d] = 1'b1;
         end
      end
   end

   // Per-cycle comparison of every core against the model.
   always @(negedge clk) begin : compare
      if (chk_en) begin
         for (int d = 0; d < 3; d++) begin
            check("in_ready",  d, 512'(o_rdy[d]),  512'(e_rdy[d]));
            check("out_valid", d, 512'(o_val[d]),  512'(e_val[d]));
            check("busy",      d, 512'(o_busy[d]), 512'(e_busy[d]));
            check("v_o",       d, o_vo[d], e_vo[d]);
         end
      end
   end

   // Present a block on group A and return the accept edge number.
   task automatic send_a(input logic [511:0] v, input logic [511:0] m,
                         input bit keep, output int k);
      int n;
      n = 0;
      a_v = v; a_m = m; a_vin = 1'b1;
      while (o_rdy[0] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", 0, 512'(n < 100), 512'(1));
      k = cyc + 1;
      @(negedge clk);
      if (!keep) a_vin = 1'b0;
   endtask

   task automatic wait_val(input int d, output int e);
      int n;
      n = 0;
      while (o_val[d] !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("valid_timeout", d, 512'(o_val[d] === 1'b1), 512'(1));
      e = cyc;
   endtask

   initial begin
      int k, e, nb, rise, nv;
      int acc[4];
      logic [511:0] raw, fin;
      rst_n = 1'b0;
      a_vin = 1'b0; a_ordy = 1'b0; a_v = '0; a_m = '0;
      b_vin = 1'b0; b_ordy = 1'b0; b_v = '0; b_m = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;

      // Known answers that pin the reference model.
      raw = model_raw(EV, '0, 7);
      fin = fold(raw, EV);
      check("model_word0", 9, 512'(fin[31:0]),  512'(32'hB94913AF));
      check("model_word1", 9, 512'(fin[63:32]), 512'(32'hA6A1F9F5));
      check("model_word2", 9, 512'(fin[95:64]), 512'(32'hEA4D40A0));
      check("model_hash",  9, 512'(fin[255:0]), 512'(HASH));
      raw = model_raw('0, '0, 1);
      check("model_zero_r1", 9, raw, '0);

      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rdy_after_reset", 0, 512'(o_rdy[0]), 512'(1));

      // Empty-input hash, latency, then backpressure with new data offered.
      send_a(EV, '0, 1'b0, k);
      wait_val(0, e);
      check("latency_r7", 0, 512'(e - k), 512'(14));
      check("hash_empty", 0, 512'(o_vo[0][255:0]), 512'(HASH));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a_vin = (i % 2 == 0);
         a_v = rand512();
         a_m = rand512();
      end
      @(negedge clk);
      check("bp_valid_held", 0, 512'(o_val[0]), 512'(1));
      check("bp_not_ready",  0, 512'(o_rdy[0]), 512'(0));
      a_vin = 1'b0;
      a_ordy = 1'b1;
      @(negedge clk);
      check("release_idle",  0, 512'(o_rdy[0]), 512'(1));
      check("release_valid", 0, 512'(o_val[0]), 512'(0));

      // ROUNDS=1 on an all-zero block.
      b_v = '0; b_m = '0; b_vin = 1'b1; b_ordy = 1'b1;
      k = cyc + 1;
      @(negedge clk);
      b_vin = 1'b0;
      nb = 0; rise = -1;
      for (int i = 0; i < 6; i++) begin
         if (o_busy[2] === 1'b1) nb++;
         if (o_val[2] === 1'b1 && rise < 0) rise = cyc;
         @(negedge clk);
      end
      check("busy_cycles_r1", 2, 512'(nb), 512'(2));
      check("latency_r1", 2, 512'(rise - k), 512'(2));
      check("zero_result_r1", 2, o_vo[2], '0);

      // Back-to-back: valid and ready held high across four blocks.
      a_ordy = 1'b1;
      for (int i = 0; i < 4; i++) send_a(rand512(), rand512(), 1'b1, acc[i]);
      a_vin = 1'b0;
      for (int i = 0; i < 3; i++) check("b2b_spacing", 0, 512'(acc[i+1] - acc[i]), 512'(16));
      repeat (20) @(negedge clk);

      // Reset five edges after accept aborts the block.
      send_a(rand512(), rand512(), 1'b0, k);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rdy_after_abort", 0, 512'(o_rdy[0]), 512'(1));
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         if (o_val[0] !== 1'b0) nv++;
         @(negedge clk);
      end
      check("abort_no_valid", 0, 512'(nv), 512'(0));
      send_a(rand512(), rand512(), 1'b0, k);
      wait_val(0, e);
      check("latency_after_abort", 0, 512'(e - k), 512'(14));
      @(negedge clk);

      // Random traffic with random backpressure on both groups.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         a_vin  = ($urandom_range(0, 3) != 0);
         a_ordy = ($urandom_range(0, 2) != 0);
         a_v = rand512(); a_m = rand512();
         b_vin  = ($urandom_range(0, 1) != 0);
         b_ordy = ($urandom_range(0, 2) != 0);
         b_v = rand512(); b_m = rand512();
      end
      @(negedge clk);
      a_vin = 1'b0; b_vin = 1'b0; a_ordy = 1'b1; b_ordy = 1'b1;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
